spi_cfg_master: RTL and testbench



---
 rtl/spi_cfg_pkg.sv | 33 +++
 rtl/spi_cfg_fifo.sv | 58 +++++
 rtl/spi_cfg_master.sv | 172 +++++++++++++++++
 tb/tb_spi_cfg_master.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared types and constants for the SPI configuration master,
// the SPI register peripheral and their benches.
package spi_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        HOLD,
        GAP
    } state_t;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned WRITE_BIT  = 15;

    localparam logic [6:0] ADDR_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_DUTY     = 7'h04;

    function automatic logic [FRAME_BITS-1:0] make_frame(
        input logic [6:0] addr,
        input logic [7:0] data
    );
        logic [FRAME_BITS-1:0] f;
        f = {1'b0, addr, data};
        f[WRITE_BIT] = 1'b1;
        return f;
    endfunction

endpackage

// File: rtl/spi_cfg_fifo.sv
// Synchronous request FIFO with occupancy output.
// A pop in the same cycle lets a push land even when full.
module spi_cfg_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 15
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/spi_cfg_master.sv
// SPI write-frame host for the register peripheral; optional boot
// init sequence enabled by SPI_CFG_MASTER_BOOT_INIT_EN.
module spi_cfg_master
    import spi_cfg_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned GAP_CYCLES  = 4,
    parameter logic [39:0] INIT_VALUES = 40'h0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [6:0]                    req_addr,
    input  logic [7:0]                    req_data,
    output logic                          sclk,
    output logic                          ncs,
    output logic                          copi,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int unsigned DW = $clog2(CLK_DIV);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t                state;
    logic [DW-1:0]         div_cnt;
    logic [GW-1:0]         gap_cnt;
    logic [3:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] next_frame;
    logic [FRAME_BITS-1:0] init_frame;
    logic [14:0]           fifo_rdata;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  init_active;
    logic                  div_end;

    spi_cfg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (15)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_valid && req_ready),
        .wdata ({req_addr, req_data}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

`ifdef SPI_CFG_MASTER_BOOT_INIT_EN
    logic [2:0] init_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_active <= 1'b1;
            init_idx    <= '0;
        end else if (state == IDLE && init_active) begin
            init_idx <= init_idx + 1'b1;
            if (init_idx == 3'd4) begin
                init_active <= 1'b0;
            end
        end
    end

    assign init_frame = make_frame(7'(init_idx), INIT_VALUES[8*init_idx +: 8]);
`else
    logic unused_init;

    assign init_active = 1'b0;
    assign init_frame  = '0;
    assign unused_init = ^INIT_VALUES;
`endif

    assign req_ready  = !fifo_full;
    assign fifo_pop   = (state == IDLE) && !init_active && !fifo_empty;
    assign busy       = (state != IDLE) || !fifo_empty || init_active;
    assign div_end    = (div_cnt == DIV_LAST);
    assign next_frame = init_active ? init_frame
                                    : make_frame(fifo_rdata[14:8], fifo_rdata[7:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sclk    <= 1'b0;
            ncs     <= 1'b1;
            copi    <= 1'b0;
            done    <= 1'b0;
            div_cnt <= '0;
            gap_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (init_active || !fifo_empty) begin
                        shreg   <= next_frame;
                        copi    <= next_frame[FRAME_BITS-1];
                        ncs     <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sclk    <= 1'b1;
                        state   <= HIGH;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sclk    <= 1'b0;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'd15) begin
                            state <= HOLD;
                        end else begin
                            // next bit goes out while sclk falls
                            shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
                            copi  <= shreg[FRAME_BITS-2];
                            state <= LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        sclk    <= 1'b1;
                        state   <= HIGH;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        ncs     <= 1'b1;
                        done    <= 1'b1;
                        copi    <= 1'b0;
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench for spi_cfg_master: frame decode, FIFO flow,
// mid-frame reset and (with SPI_CFG_MASTER_BOOT_INIT_EN) boot init.
module tb_spi_cfg_master;
    import spi_cfg_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready;
    logic       sclk;
    logic       ncs;
    logic       copi;
    logic       busy;
    logic       done;
    logic [2:0] fifo_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_cfg_master #(
        .FIFO_DEPTH  (4),
        .CLK_DIV     (4),
        .GAP_CYCLES  (4),
        .INIT_VALUES (40'h40_03_02_01_FF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .sclk       (sclk),
        .ncs        (ncs),
        .copi       (copi),
        .busy       (busy),
        .done       (done),
        .fifo_level (fifo_level)
    );

    // Bus monitor and tiny peripheral model, sampling pre-edge values.
    logic        ncs_q = 1'b1;
    logic        sclk_q = 1'b0;
    logic        copi_q = 1'b0;
    logic [15:0] sh = '0;
    int          rises = 0;
    int          low_cnt = 0;
    int          hi_cnt = 0;
    logic [15:0] frames[$];
    int          lens[$];
    int          gaps[$];
    int          done_n = 0;
    int          aborted_n = 0;
    int          viol_n = 0;
    logic [7:0]  periph [5] = '{default: 8'h00};

    always @(posedge clk) begin
        int a;
        if (done) done_n++;
        if (!ncs && ncs_q) begin
            gaps.push_back(hi_cnt);
            low_cnt = 0;
            rises = 0;
            sh = '0;
        end
        if (ncs && !ncs_q) begin
            if (rises == 16) begin
                frames.push_back(sh);
                lens.push_back(low_cnt);
                a = int'(sh[14:8]);
                if (sh[15] && a < 5) periph[a] = sh[7:0];
            end else begin
                aborted_n++;
            end
            hi_cnt = 0;
        end
        if (!ncs) begin
            low_cnt++;
            if (sclk && !sclk_q) begin
                sh = {sh[14:0], copi};
                rises++;
            end
            if (sclk && sclk_q && copi !== copi_q) viol_n++;
        end else begin
            hi_cnt++;
        end
        ncs_q = ncs;
        sclk_q = sclk;
        copi_q = copi;
    end

    task automatic push(input logic [6:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr = a;
        req_data = d;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_ready: ready=%b required 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input string name);
        int n = 0;
        while (frames.size() < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frames.size() < target) begin
            errors++;
            $display("FAIL %s_frames: got %0d required %0d", name, frames.size(), target);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        logic exp_busy;
`ifdef SPI_CFG_MASTER_BOOT_INIT_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 7;
        if (sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b required 0", sclk); end
        if (ncs !== 1'b1) begin errors++; $display("FAIL rst_ncs: got %b required 1", ncs); end
        if (copi !== 1'b0) begin errors++; $display("FAIL rst_copi: got %b required 0", copi); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
        if (busy !== exp_busy) begin errors++; $display("FAIL rst_busy: got %b required %b", busy, exp_busy); end
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d required 0", fifo_level); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b required 1", req_ready); end
        rst_n = 1'b1;
    endtask

`ifdef SPI_CFG_MASTER_BOOT_INIT_EN
    task automatic test_boot_init();
        logic [15:0] exp [5] = '{16'h80FF, 16'h8101, 16'h8202, 16'h8303, 16'h8440};
        int d0 = done_n;
        wait_frames(5, "boot");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (frames[i] !== exp[i]) begin
                errors++;
                $display("FAIL boot_frame%0d: got %h required %h", i, frames[i], exp[i]);
            end
        end
        wait_idle("boot");
        checks += 2;
        if (periph[4] !== 8'h40) begin errors++; $display("FAIL boot_duty: got %h required 40", periph[4]); end
        if (done_n - d0 != 5) begin errors++; $display("FAIL boot_done: got %0d required 5", done_n - d0); end
    endtask
`endif

    task automatic test_single_write();
        int f0;
        int d0;
        wait_idle("single_pre");
        f0 = frames.size();
        d0 = done_n;
        push(ADDR_DUTY, 8'h80);
        wait_frames(f0 + 1, "single");
        wait_idle("single");
        checks += 5;
        if (frames[f0] !== 16'h8480) begin errors++; $display("FAIL single_frame: got %h required 8480", frames[f0]); end
        if (lens[f0] != 132) begin errors++; $display("FAIL single_len: got %0d required 132", lens[f0]); end
        if (done_n - d0 != 1) begin errors++; $display("FAIL single_done: got %0d required 1", done_n - d0); end
        if (periph[4] !== 8'h80) begin errors++; $display("FAIL single_duty: got %h required 80", periph[4]); end
        if (viol_n != 0) begin errors++; $display("FAIL single_copi_stable: got %0d changes required 0", viol_n); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp [4] = '{16'h80AA, 16'h8155, 16'h82F0, 16'h830F};
        logic [7:0]  reg_exp [4] = '{8'hAA, 8'h55, 8'hF0, 8'h0F};
        int f0;
        int g0;
        wait_idle("b2b_pre");
        f0 = frames.size();
        g0 = gaps.size();
        push(ADDR_OUT_7_0, 8'hAA);
        push(ADDR_OUT_15_8, 8'h55);
        push(ADDR_PWM_7_0, 8'hF0);
        push(ADDR_PWM_15_8, 8'h0F);
        wait_frames(f0 + 4, "b2b");
        wait_idle("b2b");
        for (int i = 0; i < 4; i++) begin
            checks += 3;
            if (frames[f0+i] !== exp[i]) begin
                errors++;
                $display("FAIL b2b_frame%0d: got %h required %h", i, frames[f0+i], exp[i]);
            end
            if (lens[f0+i] != 132) begin
                errors++;
                $display("FAIL b2b_len%0d: got %0d required 132", i, lens[f0+i]);
            end
            if (periph[i] !== reg_exp[i]) begin
                errors++;
                $display("FAIL b2b_reg%0d: got %h required %h", i, periph[i], reg_exp[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (gaps[g0+i] != 5) begin
                errors++;
                $display("FAIL b2b_gap%0d: got %0d required 5", i, gaps[g0+i]);
            end
        end
    endtask

    task automatic test_full();
        logic [15:0] exp [6] = '{16'h8011, 16'h8122, 16'h8233,
                                 16'h8344, 16'h8455, 16'h8066};
        int f0;
        wait_idle("full_pre");
        f0 = frames.size();
        push(7'h00, 8'h11);
        push(7'h01, 8'h22);
        push(7'h02, 8'h33);
        push(7'h03, 8'h44);
        push(7'h04, 8'h55);
        checks += 2;
        if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_level: got %0d required 4", fifo_level); end
        if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b required 0", req_ready); end
        push(7'h00, 8'h66);
        checks++;
        if (fifo_level !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d required 4", fifo_level); end
        wait_frames(f0 + 6, "full");
        wait_idle("full");
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (frames[f0+i] !== exp[i]) begin
                errors++;
                $display("FAIL full_frame%0d: got %h required %h", i, frames[f0+i], exp[i]);
            end
        end
    endtask

    task automatic test_bad_addr();
        logic [7:0] reg_exp [5] = '{8'h66, 8'h22, 8'h33, 8'h44, 8'h55};
        int f0;
        int d0;
        wait_idle("bad_pre");
        f0 = frames.size();
        d0 = done_n;
        push(7'h7F, 8'h12);
        wait_frames(f0 + 1, "bad");
        wait_idle("bad");
        checks += 2;
        if (frames[f0] !== 16'hFF12) begin errors++; $display("FAIL bad_frame: got %h required ff12", frames[f0]); end
        if (done_n - d0 != 1) begin errors++; $display("FAIL bad_done: got %0d required 1", done_n - d0); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (periph[i] !== reg_exp[i]) begin
                errors++;
                $display("FAIL bad_reg%0d: got %h required %h", i, periph[i], reg_exp[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        int f0;
        int ab0;
        int n = 0;
        wait_idle("mrst_pre");
        ab0 = aborted_n;
        push(ADDR_OUT_15_8, 8'h99);
        while (!(ncs === 1'b0 && rises == 7) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rises != 7) begin errors++; $display("FAIL mrst_wait: got %0d rises required 7", rises); end
        rst_n = 1'b0;
        #1;
        checks += 5;
        if (ncs !== 1'b1) begin errors++; $display("FAIL mrst_ncs: got %b required 1", ncs); end
        if (sclk !== 1'b0) begin errors++; $display("FAIL mrst_sclk: got %b required 0", sclk); end
        if (copi !== 1'b0) begin errors++; $display("FAIL mrst_copi: got %b required 0", copi); end
        if (fifo_level !== 3'd0) begin errors++; $display("FAIL mrst_level: got %0d required 0", fifo_level); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready: got %b required 1", req_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks += 2;
        if (aborted_n - ab0 != 1) begin errors++; $display("FAIL mrst_abort: got %0d required 1", aborted_n - ab0); end
        if (periph[1] !== 8'h22) begin errors++; $display("FAIL mrst_reg: got %h required 22", periph[1]); end
        wait_idle("mrst_post");
        f0 = frames.size();
        push(ADDR_OUT_15_8, 8'hC3);
        wait_frames(f0 + 1, "mrst");
        wait_idle("mrst");
        checks += 3;
        if (frames[f0] !== 16'h81C3) begin errors++; $display("FAIL mrst_frame: got %h required 81c3", frames[f0]); end
        if (lens[f0] != 132) begin errors++; $display("FAIL mrst_len: got %0d required 132", lens[f0]); end
        if (periph[1] !== 8'hC3) begin errors++; $display("FAIL mrst_reg_new: got %h required c3", periph[1]); end
    endtask

    initial begin
        test_reset();
`ifdef SPI_CFG_MASTER_BOOT_INIT_EN
        test_boot_init();
`endif
        test_single_write();
        test_back_to_back();
        test_full();
        test_bad_addr();
        test_mid_reset();
        checks++;
        if (viol_n != 0) begin
            errors++;
            $display("FAIL copi_stable: got %0d changes required 0", viol_n);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
